// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        SEND,
        WAIT_START,
        WAIT_DONE,
        ACK
    } sched_state_t;

    localparam int         DELAY_W       = 4;
    localparam logic [3:0] START_PATTERN = 4'b1101;

    // Bit idx of the 8-bit serial frame: start pattern MSB first, then delay MSB first.
    function automatic logic serial_bit(input logic [2:0] idx, input logic [DELAY_W-1:0] delay);
        logic [7:0] frame;
        frame = {START_PATTERN, delay};
        return frame[3'd7 - idx];
    endfunction

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping mod N_REQ.
// Latency: combinational.
// Backpressure: none; the caller decides when a pick is taken.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan N_REQ candidates starting at ptr; the first one requesting wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one serial-started countdown timer between N_REQ requesters, round-robin.
// Latency: grant 1 cycle after req, then GAP_CYCLES gap + 8 serial bits before the timer runs.
// Backpressure: requests are held by the requester until its cpl/err pulse; arbitration only in IDLE.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int GAP_CYCLES    = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [DELAY_W*N_REQ-1:0]   req_delay,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           cpl,
    output logic [N_REQ-1:0]           err,
    output logic                       busy,
    output logic                       tmr_data,
    output logic                       tmr_ack,
    input  logic                       tmr_counting,
    input  logic                       tmr_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    // err is registered, so the abort decision is taken one count early; that puts
    // the err pulse exactly START_TIMEOUT cycles after the last delay bit.
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((START_TIMEOUT >= 2) ? START_TIMEOUT - 2 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    sched_state_t       state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [DELAY_W-1:0] delay_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [2:0]         bit_idx;
    logic [TO_W-1:0]    to_cnt;

    logic [N_REQ-1:0]   win_gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .vld (win_vld)
    );

    // Service FSM: arbitrate, flush the timer's detector, serialise the frame,
    // wait for the timer to start and finish, then run the ack handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            cpl      <= '0;
            err      <= '0;
            busy     <= 1'b0;
            tmr_data <= 1'b0;
            tmr_ack  <= 1'b0;
            delay_q  <= '0;
            gap_cnt  <= '0;
            bit_idx  <= '0;
            to_cnt   <= '0;
        end else begin
            cpl <= '0;
            err <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant   <= win_gnt;
                        delay_q <= req_delay[win_idx*DELAY_W +: DELAY_W];
                        rr_ptr  <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
                        gap_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        bit_idx  <= '0;
                        tmr_data <= serial_bit(3'd0, delay_q);
                        state    <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (bit_idx == 3'd7) begin
                        tmr_data <= 1'b0;
                        to_cnt   <= '0;
                        state    <= WAIT_START;
                    end else begin
                        bit_idx  <= bit_idx + 3'd1;
                        tmr_data <= serial_bit(bit_idx + 3'd1, delay_q);
                    end
                end
                WAIT_START: begin
                    if (tmr_done) begin
                        // Zero-delay timers can finish before counting is ever seen.
                        tmr_ack <= 1'b1;
                        state   <= ACK;
                    end else if (tmr_counting) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt >= TO_LAST) begin
                        err   <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tmr_done) begin
                        tmr_ack <= 1'b1;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (!tmr_done) begin
                        tmr_ack <= 1'b0;
                        cpl     <= grant;
                        grant   <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler with a behavioural serial timer.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_scheduler;

    localparam int N_REQ         = 4;
    localparam int GAP_CYCLES    = 4;
    localparam int START_TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_REQ-1:0]     req;
    logic [4*N_REQ-1:0]   req_delay;
    logic [N_REQ-1:0]     grant, cpl, err;
    logic                 busy, tmr_data, tmr_ack;
    logic                 tmr_counting, tmr_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] exp_grant[$];
    logic [31:0] exp_pat[$];
    logic [31:0] exp_ack[$];
    logic [31:0] exp_cpl[$];
    logic [31:0] exp_err[$];

    // timer model controls
    int scale       = 10;
    int hold_extra  = 0;
    bit never_count = 1'b0;

    timer_scheduler #(
        .N_REQ         (N_REQ),
        .GAP_CYCLES    (GAP_CYCLES),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_delay    (req_delay),
        .grant        (grant),
        .cpl          (cpl),
        .err          (err),
        .busy         (busy),
        .tmr_data     (tmr_data),
        .tmr_ack      (tmr_ack),
        .tmr_counting (tmr_counting),
        .tmr_done     (tmr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_service(input logic [3:0] oh, input logic [3:0] dly, input int ack_len);
        exp_grant.push_back(32'(oh));
        exp_pat.push_back({20'd0, 4'b0000, 4'b1101, dly});
        exp_ack.push_back(32'(ack_len));
        exp_cpl.push_back(32'(oh));
    endtask

    task automatic expect_timeout(input logic [3:0] oh, input logic [3:0] dly);
        exp_grant.push_back(32'(oh));
        exp_pat.push_back({20'd0, 4'b0000, 4'b1101, dly});
        exp_err.push_back(32'(oh));
    endtask

    task automatic wait_resp(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpl == '0 && err == '0 && n < budget);
        if (cpl == '0 && err == '0) begin
            tests++;
            fails++;
            $display("FAIL resp_wait: no cpl/err within %0d cycles", budget);
        end
    endtask

    task automatic wait_grant(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < budget);
        if (grant == '0) begin
            tests++;
            fails++;
            $display("FAIL grant_wait: no grant within %0d cycles", budget);
        end
    endtask

    // Behavioural timer: detect 1101, take 4 delay bits, count, raise done, hold until ack.
    initial begin
        logic [3:0] sh, dly;
        int tm_st, nb, tcnt, holdc;
        tmr_counting = 1'b0;
        tmr_done     = 1'b0;
        sh = '0; dly = '0; tm_st = 0; nb = 0; tcnt = 0; holdc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                tm_st = 0; sh = '0;
                tmr_counting = 1'b0;
                tmr_done     = 1'b0;
            end else begin
                case (tm_st)
                    0: begin
                        sh = {sh[2:0], tmr_data};
                        if (sh == 4'b1101) begin tm_st = 1; nb = 0; end
                    end
                    1: begin
                        dly = {dly[2:0], tmr_data};
                        nb++;
                        if (nb == 4) tm_st = 2;
                    end
                    2: begin
                        if (never_count) begin
                            tm_st = 0; sh = '0;
                        end else begin
                            tmr_counting = 1'b1;
                            tcnt  = (int'(dly) + 1) * scale;
                            tm_st = 3;
                        end
                    end
                    3: begin
                        tcnt--;
                        if (tcnt <= 0) begin
                            tmr_counting = 1'b0;
                            tmr_done     = 1'b1;
                            tm_st        = 4;
                        end
                    end
                    4: begin
                        if (tmr_ack) begin
                            if (hold_extra == 0) begin
                                tmr_done = 1'b0; tm_st = 0; sh = '0;
                            end else begin
                                holdc = hold_extra; tm_st = 5;
                            end
                        end
                    end
                    default: begin
                        holdc--;
                        if (holdc <= 0) begin
                            tmr_done = 1'b0; tm_st = 0; sh = '0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents grant, frame, ack, cpl or err.
    initial begin
        logic [N_REQ-1:0] prev_grant;
        logic [11:0]      cap_bits;
        bit               cap_on;
        int               cap_idx, ack_run, last_bit_cyc;
        prev_grant = '0; cap_bits = '0; cap_on = 1'b0;
        cap_idx = 0; ack_run = 0; last_bit_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                prev_grant = '0; cap_on = 1'b0; ack_run = 0;
            end else begin
                if (grant != '0 && prev_grant == '0) begin
                    if (exp_grant.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL grant_unexpected: got %b", grant);
                    end else begin
                        check("grant", 32'(grant), exp_grant.pop_front());
                    end
                    check("busy_on_grant", 32'(busy), 32'd1);
                    cap_on = 1'b1; cap_idx = 0; cap_bits = '0;
                end
                if (cap_on) begin
                    cap_bits = {cap_bits[10:0], tmr_data};
                    cap_idx++;
                    if (cap_idx == 12) begin
                        cap_on = 1'b0;
                        last_bit_cyc = cyc;
                        if (exp_pat.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL frame_unexpected: got %b", cap_bits);
                        end else begin
                            check("gap_and_frame", 32'(cap_bits), exp_pat.pop_front());
                        end
                    end
                end
                if (tmr_ack) begin
                    ack_run++;
                end else if (ack_run != 0) begin
                    if (exp_ack.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL ack_unexpected: got run of %0d", ack_run);
                    end else begin
                        check("ack_high_cycles", 32'(ack_run), exp_ack.pop_front());
                    end
                    ack_run = 0;
                end
                if (cpl != '0) begin
                    if (exp_cpl.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL cpl_unexpected: got %b", cpl);
                    end else begin
                        check("cpl", 32'(cpl), exp_cpl.pop_front());
                    end
                    check("cpl_state", {29'd0, busy, |grant, tmr_ack}, 32'd0);
                end
                if (err != '0) begin
                    if (exp_err.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL err_unexpected: got %b", err);
                    end else begin
                        check("err", 32'(err), exp_err.pop_front());
                    end
                    check("err_latency", 32'(cyc - last_bit_cyc), 32'(START_TIMEOUT));
                    check("err_grant_clear", {31'd0, |grant}, 32'd0);
                end
                prev_grant = grant;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    // Stimulus
    initial begin
        reset     = 1'b0;
        req       = '0;
        req_delay = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_pulses", 32'({cpl, err}), 32'd0);
        check("rst_ctrl", {29'd0, busy, tmr_data, tmr_ack}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single request, long count.
        scale = 1000; hold_extra = 0;
        req_delay[3:0] = 4'b0101;
        expect_service(4'b0001, 4'b0101, 1);
        req = 4'b0001;
        @(negedge clk);
        check("grant_latency", 32'(grant), 32'h1);
        wait_resp(20000);
        req = '0;
        repeat (3) @(negedge clk);

        // Round robin from a fresh pointer.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        scale = 10;
        req_delay = {4'd4, 4'd3, 4'd2, 4'd1};
        expect_service(4'b0001, 4'd1, 1);
        expect_service(4'b0010, 4'd2, 1);
        expect_service(4'b0100, 4'd3, 1);
        expect_service(4'b1000, 4'd4, 1);
        expect_service(4'b0001, 4'd1, 1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_resp(2000);
        req = '0;
        repeat (3) @(negedge clk);

        // Start timeout: pointer is at 1, only requester 2 asks.
        never_count = 1'b1;
        req_delay[11:8] = 4'b1010;
        expect_timeout(4'b0100, 4'b1010);
        req = 4'b0100;
        wait_resp(2000);
        req = '0;
        never_count = 1'b0;
        repeat (3) @(negedge clk);

        // Requester 2 drops req while the timer counts.
        req_delay[11:8] = 4'b0011;
        expect_service(4'b0100, 4'b0011, 1);
        req = 4'b0100;
        begin
            int n;
            n = 0;
            while (!tmr_counting && n < 200) begin @(negedge clk); n++; end
        end
        repeat (5) @(negedge clk);
        req = '0;
        wait_resp(2000);
        repeat (3) @(negedge clk);

        // Timer holds done 3 cycles after ack rises.
        hold_extra = 3;
        req_delay[15:12] = 4'b0110;
        expect_service(4'b1000, 4'b0110, 4);
        req = 4'b1000;
        wait_resp(2000);
        req = '0;
        hold_extra = 0;
        repeat (3) @(negedge clk);

        // Reset while the 4th pattern bit is on the line.
        req_delay[3:0] = 4'b0111;
        exp_grant.push_back(32'h1);
        req = 4'b0001;
        wait_grant(100);
        repeat (GAP_CYCLES + 3) @(negedge clk);
        check("pre_reset_bit4", 32'(tmr_data), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_tmr_data", 32'(tmr_data), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        req = 4'b0010;
        req_delay[7:4] = 4'b1001;
        expect_service(4'b0010, 4'b1001, 1);
        reset = 1'b1;
        wait_resp(2000);
        req = '0;
        repeat (5) @(negedge clk);

        check("left_grant", 32'(exp_grant.size()), 32'd0);
        check("left_frame", 32'(exp_pat.size()), 32'd0);
        check("left_ack", 32'(exp_ack.size()), 32'd0);
        check("left_cpl", 32'(exp_cpl.size()), 32'd0);
        check("left_err", 32'(exp_err.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
- Shares one serial-configured pattern-triggered countdown timer between N_REQ requesters.
- Arbitrates requests round-robin and serialises the start pattern 1101 plus the granted 4-bit delay onto the timer's data line.
- Monitors the timer's counting/done outputs, issues ack, and returns a per-requester completion or error pulse.
- Sits between the requesting control blocks and the single timer instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 4, cycles of data=0 driven before each pattern to flush the timer's pattern detector (min 4).
- START_TIMEOUT, 16, max cycles after the last delay bit to wait for tmr_counting=1 before aborting.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester level request, held until cpl or err for that requester
- req_delay  in  4*N_REQ  requester i's delay in bits [4i+3:4i]
- grant  out  N_REQ  one-hot owner of the timer, held for the whole service
- cpl  out  N_REQ  one-cycle completion pulse to the owner
- err  out  N_REQ  one-cycle abort pulse to the owner (start timeout)
- busy  out  1  high in every state except IDLE
- tmr_data  out  1  serial stream to the timer
- tmr_ack  out  1  acknowledge to the timer
- tmr_counting  in  1  timer counting flag
- tmr_done  in  1  timer done flag

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, rr pointer=0, grant=0, cpl=0, err=0, busy=0, tmr_data=0, tmr_ack=0, delay register=0.
- IDLE:
  - If any req is high, select the first requester at or after the rr pointer (wrapping mod N_REQ).
  - Register its req_delay, set grant one-hot, set rr pointer to winner+1 mod N_REQ, go to GAP.
  - Grant is visible 1 cycle after req is sampled.
- GAP: tmr_data=0 for GAP_CYCLES cycles, then go to SEND.
- SEND:
  - Drive 8 bits, one per cycle: 1,1,0,1 then delay[3],delay[2],delay[1],delay[0].
  - A 3-bit index counts 0..7; at index 7 go to WAIT_START with a timeout counter of 0.
  - tmr_data=0 in every state other than SEND.
- WAIT_START:
  - If tmr_counting=1, go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches START_TIMEOUT-1 with no counting, pulse err[owner] for 1 cycle, clear grant, go to IDLE.
  - If tmr_done=1 arrives in this state (delay-0 fast path), go directly to ACK.
- WAIT_DONE: no timeout. When tmr_done=1, go to ACK.
- ACK:
  - Hold tmr_ack=1 until tmr_done is sampled 0.
  - On that cycle drive tmr_ack=0, pulse cpl[owner] for 1 cycle, clear grant, go to IDLE.
- Arbitration:
  - Arbitration occurs only in IDLE.
  - req changes during service are ignored. Dropping req mid-service does not abort; cpl still pulses.
  - A requester that re-requests on the cpl cycle competes normally. Because the rr pointer has advanced, others win first.
- Widths: rr pointer $clog2(N_REQ) bits; gap counter $clog2(GAP_CYCLES+1) bits; timeout counter $clog2(START_TIMEOUT+1) bits; all wrap-free (saturating compare, never overflow).
- Mid-operation reset: all outputs return to reset values immediately. The timer is reset from the same source, so no partial pattern survives. After release, a request is serviced from GAP normally.
- tmr_done=1 in IDLE/GAP/SEND is ignored (stale); it has no effect on grant, cpl or err.

Decomposition:
- Shared package timer_sched_pkg:
  - state enum sched_state_t {IDLE, GAP, SEND, WAIT_START, WAIT_DONE, ACK}
  - constant START_PATTERN = 4'b1101
  - constant DELAY_W = 4
- One sub-module: rr_arbiter (N_REQ request vector + pointer in, one-hot winner + valid out, combinational).
- The FSM, counters and serialiser stay in timer_scheduler.

Test Plan:
- Single request: req=0001, req_delay[3:0]=4'b0101, timer model counts (delay+1)*1000 cycles.
  - Response: grant=0001 next cycle; tmr_data =0 for 4 cycles then 1,1,0,1,0,1,0,1; done answered with tmr_ack; cpl=0001 single pulse; busy falls the same cycle.
- Round-robin fairness: req=1111 held continuously for 4 services.
  - Response: grant order 0001,0010,0100,1000; the 5th grant is 0001.
- Start timeout: timer model never raises counting.
  - Response: err[owner] pulses exactly START_TIMEOUT cycles after the last delay bit; grant clears; no cpl.
- Req dropped mid-service: req[2] deasserted during WAIT_DONE.
  - Response: service completes; cpl=0100 pulses; tmr_ack handshake completes normally.
- Reset in SEND: assert reset after the 3rd pattern bit.
  - Response: tmr_data=0, grant=0, busy=0 immediately; after release with req=0010, a full GAP+SEND sequence occurs.
- Ack hold: timer model holds done high for 3 cycles after ack rises.
  - Response: tmr_ack stays 1 until done samples 0; exactly one cpl pulse.
